// File: rtl/cube_root.sv
// cube_root: iterative integer cube root, y_bo = floor(cbrt(a_bi)).
//
// Uses the digit-by-digit restoring algorithm. Each of the IN_W/3 result
// bits takes OUT_W+2 cycles: one PREP cycle, OUT_W shift-add multiplier
// cycles and one SUB cycle. No hard multipliers are used.
//
// Optional feature macro: CUBE_ROOT_REM_EN adds the r_bo remainder port.
//
// Ports:
//   clk_i    in   1      clock, rising edge
//   rst_i    in   1      synchronous reset, active-high
//   a_bi     in   IN_W   unsigned radicand, sampled on the accepting edge
//   start_i  in   1      start request, honoured only when idle
//   busy_o   out  1      high while a computation is in progress
//   y_bo     out  OUT_W  result, held between completions
//   r_bo     out  IN_W   remainder a_bi - y_bo^3 (CUBE_ROOT_REM_EN only)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i; outputs hold the last result
// PREP  | double y, load multiplier with 2y and 2y+1
// MUL   | one multiplier bit per cycle, acc = 2y*(2y+1)
// SUB   | trial-subtract (3*acc+1)<<s, decide the next result bit

module cube_root #(
    parameter int IN_W = 24,
    localparam int OUT_W = IN_W / 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IN_W-1:0]  a_bi,
    input  logic             start_i,
    output logic             busy_o,
    output logic [OUT_W-1:0] y_bo
`ifdef CUBE_ROOT_REM_EN
    ,
    output logic [IN_W-1:0]  r_bo
`endif
);

    localparam int S_W   = $clog2(IN_W);
    localparam int C_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ACC_W = 2 * OUT_W;
    localparam int B_W   = IN_W + 2 * OUT_W + 3;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        MUL,
        SUB
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IN_W-1:0]  x;
    logic [OUT_W-1:0] y;
    logic [S_W-1:0]   s;
    logic [OUT_W-1:0] mcand;
    logic [OUT_W-1:0] mplier;
    logic [ACC_W-1:0] acc;
    logic [C_W-1:0]   cnt;

    logic [ACC_W-1:0] step;
    logic [B_W-1:0]   b_val;
    logic             x_ge;
    logic [IN_W-1:0]  x_sub;
    logic [OUT_W-1:0] y_inc;

    wire mul_last = (cnt == C_W'(OUT_W - 1));
    wire s_zero   = (s == '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_i) state_nxt = PREP;
            PREP:    state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = SUB;
            SUB:     state_nxt = s_zero ? IDLE : PREP;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o = (state != IDLE);
    end

    // Shifted partial product for the current multiplier bit
    assign step  = ACC_W'(mcand) << cnt;

    // 3*acc+1 built from shift-add, then aligned to the current digit.
    // Wide enough that the shift never drops bits, so the compare is exact.
    assign b_val = ((B_W'(acc) << 1) + B_W'(acc) + B_W'(1)) << s;
    assign x_ge  = (B_W'(x) >= b_val);
    // Only used when x_ge, in which case b_val fits in IN_W bits.
    assign x_sub = x - b_val[IN_W-1:0];
    assign y_inc = y + OUT_W'(x_ge);

    // Datapath
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x      <= '0;
            y      <= '0;
            s      <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            y_bo   <= '0;
`ifdef CUBE_ROOT_REM_EN
            r_bo   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        x <= a_bi;
                        y <= '0;
                        s <= S_W'(IN_W - 3);
                    end
                end
                PREP: begin
                    y      <= y << 1;
                    mcand  <= y << 1;
                    mplier <= (y << 1) + OUT_W'(1);
                    acc    <= '0;
                    cnt    <= '0;
                end
                MUL: begin
                    if (mplier[cnt]) acc <= acc + step;
                    cnt <= cnt + C_W'(1);
                end
                SUB: begin
                    if (x_ge) begin
                        x <= x_sub;
                        y <= y_inc;
                    end
                    if (s_zero) begin
                        y_bo <= y_inc;
`ifdef CUBE_ROOT_REM_EN
                        r_bo <= x_ge ? x_sub : x;
`endif
                    end else begin
                        s <= s - S_W'(3);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
